// File: rtl/lutram_request_controller_pkg.sv
// Shared definitions for the distributed-RAM request controller: FSM state encodings.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

package lutram_request_controller_pkg;

    typedef enum logic [0:0] {
        STATE_INIT = 1'b0,
        STATE_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/lutram_response_fifo.sv
// Circular response buffer with occupancy count; head entry is presented while count is non-zero.
module lutram_response_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_s;
    logic             pop_s;

    assign valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s   = valid_s & pop_ready;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (srst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign valid = valid_s;
    assign data  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/lutram_request_controller.sv
// Initiator front end for the dual-port distributed RAM: zero-fills every set after reset,
// then forwards byte-masked writes and credit-limited reads, buffering read data in order.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module lutram_request_controller
    import lutram_request_controller_pkg::*;
#(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET) + 1,
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int RSP_BUFFER_DEPTH           = 4
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n_in,
    input  logic                                  req_valid_in,
    output logic                                  req_ready_out,
    input  logic                                  req_is_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      req_set_addr_in,
    input  logic [WRITE_MASK_LEN-1:0]             req_byte_en_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] req_data_in,
    output logic                                  rsp_valid_out,
    input  logic                                  rsp_ready_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] rsp_data_out,
    output logic                                  rsp_hit_out,
    output logic                                  init_done_out,
    output logic                                  mem_write_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             mem_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      mem_write_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_write_data_out,
    output logic                                  mem_read_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      mem_read_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_read_data_in,
    input  logic                                  mem_read_valid_in
);

    localparam int FIFO_WIDTH = SINGLE_ENTRY_WIDTH_IN_BITS + 1;
    localparam int FIFO_CNT_W = $clog2(RSP_BUFFER_DEPTH) + 1;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
    localparam logic [FIFO_CNT_W:0] CREDIT_LIMIT = RSP_BUFFER_DEPTH[FIFO_CNT_W:0];

    ctrl_state_e                        state_r;
    ctrl_state_e                        state_next_s;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]   init_cnt_r;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]   init_cnt_next_s;
    logic                               read_pending_r;
    logic                               read_pending_next_s;

    logic                               req_ready_s;
    logic                               accept_s;
    logic                               credit_ok_s;
    logic [FIFO_CNT_W:0]                outstanding_s;
    logic                               wr_access_en_s;
    logic [WRITE_MASK_LEN-1:0]          wr_en_s;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]   wr_addr_s;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] wr_data_s;
    logic                               rd_access_en_s;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]   rd_addr_s;

    logic                               fifo_valid_s;
    logic [FIFO_WIDTH-1:0]              fifo_data_s;
    logic [FIFO_CNT_W-1:0]              fifo_count_s;

    // Read credits come from registered state only, so rsp_ready_in never reaches req_ready_out.
    assign outstanding_s = {1'b0, fifo_count_s} + {{FIFO_CNT_W{1'b0}}, read_pending_r};
    assign credit_ok_s   = (outstanding_s < CREDIT_LIMIT);
    assign accept_s      = req_valid_in & req_ready_s;

    // FSM state, zero-fill counter and the one-cycle read-in-flight flag.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r        <= STATE_INIT;
            init_cnt_r     <= {SET_PTR_WIDTH_IN_BITS{1'b0}};
            read_pending_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            init_cnt_r     <= init_cnt_next_s;
            read_pending_r <= read_pending_next_s;
        end
    end

    // Next-state and memory-port decode. The zero-fill enables are gated by reset_n_in so the
    // write port is quiet while reset is held.
    always_comb begin
        state_next_s        = state_r;
        init_cnt_next_s     = init_cnt_r;
        read_pending_next_s = 1'b0;
        req_ready_s         = 1'b0;
        wr_access_en_s      = 1'b0;
        wr_en_s             = {WRITE_MASK_LEN{1'b0}};
        wr_addr_s           = {SET_PTR_WIDTH_IN_BITS{1'b0}};
        wr_data_s           = {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
        rd_access_en_s      = 1'b0;
        rd_addr_s           = {SET_PTR_WIDTH_IN_BITS{1'b0}};
        case (state_r)
            STATE_INIT: begin
                wr_access_en_s  = reset_n_in;
                wr_en_s         = {WRITE_MASK_LEN{reset_n_in}};
                wr_addr_s       = init_cnt_r;
                init_cnt_next_s = init_cnt_r + SET_PTR_WIDTH_IN_BITS'(1);
                if (init_cnt_r == LAST_SET) begin
                    state_next_s = STATE_RUN;
                end else begin
                    state_next_s = STATE_INIT;
                end
            end
            STATE_RUN: begin
                req_ready_s = req_is_write_in | credit_ok_s;
                if (accept_s && req_is_write_in) begin
                    wr_access_en_s = 1'b1;
                    wr_en_s        = req_byte_en_in;
                    wr_addr_s      = req_set_addr_in;
                    wr_data_s      = req_data_in;
                end else if (accept_s) begin
                    rd_access_en_s      = 1'b1;
                    rd_addr_s           = req_set_addr_in;
                    read_pending_next_s = 1'b1;
                end else begin
                    read_pending_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s = STATE_INIT;
            end
        endcase
    end

    lutram_response_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (RSP_BUFFER_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_in),
        .rst_n     (reset_n_in),
        .srst      (1'b0),
        .push      (read_pending_r),
        .push_data ({mem_read_data_in, mem_read_valid_in}),
        .pop_ready (rsp_ready_in),
        .valid     (fifo_valid_s),
        .data      (fifo_data_s),
        .count     (fifo_count_s)
    );

    assign req_ready_out           = req_ready_s;
    assign init_done_out           = (state_r == STATE_RUN);
    assign mem_write_access_en_out = wr_access_en_s;
    assign mem_write_en_out        = wr_en_s;
    assign mem_write_set_addr_out  = wr_addr_s;
    assign mem_write_data_out      = wr_data_s;
    assign mem_read_access_en_out  = rd_access_en_s;
    assign mem_read_set_addr_out   = rd_addr_s;
    assign rsp_valid_out           = fifo_valid_s;
    assign rsp_data_out            = fifo_data_s[FIFO_WIDTH-1:1];
    assign rsp_hit_out             = fifo_data_s[0];

endmodule
